// File: rtl/synapse_accumulator_pkg.sv
// Shared definitions for the synapse accumulator and its neighbouring neuron
// blocks: parameter defaults, the accumulator FSM state encoding and a helper
// that sizes index/address buses.
package synapse_accumulator_pkg;

  localparam int DEFAULT_NUM_INPUTS    = 8;
  localparam int DEFAULT_DATA_LENGTH   = 8;
  localparam int DEFAULT_WEIGHT_LENGTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } syn_state_t;

  // Width of an index able to address n entries; a single entry still
  // needs a one-bit bus so the port never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/synapse_weight_regfile.sv
// Synaptic weight storage.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (weights clear to 0)
//   we, waddr, wdata  single write port, written on the rising edge
//   raddr, rdata      combinational read port driven by the accumulator index
// A read and a write to the same entry in one cycle returns the old weight;
// the new value is visible from the following cycle.
module synapse_weight_regfile
  import synapse_accumulator_pkg::*;
#(
  parameter int NUM_ENTRIES = DEFAULT_NUM_INPUTS,
  parameter int WIDTH       = DEFAULT_WEIGHT_LENGTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [idx_width(NUM_ENTRIES)-1:0] waddr,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic [idx_width(NUM_ENTRIES)-1:0] raddr,
  output logic [WIDTH-1:0]                  rdata
);

  logic [WIDTH-1:0] mem [NUM_ENTRIES];

  // Out-of-range addresses (non power-of-two sizes) are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < NUM_ENTRIES)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synapse_accumulator.sv
// Synapse accumulator: on each timestep strobe, latches the presynaptic spike
// vector and serially sums the weights of the active inputs, one input per
// cycle, saturating at the maximum output current.
// Ports:
//   i_clk, i_rst_n            clock and asynchronous active-low reset
//   i_weight_we/addr/data     weight write port, accepted in any state
//   i_start                   timestep strobe, honoured only when idle
//   i_spikes                  presynaptic spike vector, latched on start
//   o_busy                    high while a sum is in progress
//   o_valid                   one-cycle pulse when o_current updates
//   o_current                 saturated weighted sum, held between pulses
module synapse_accumulator
  import synapse_accumulator_pkg::*;
#(
  parameter int NUM_INPUTS    = DEFAULT_NUM_INPUTS,
  parameter int DATA_LENGTH   = DEFAULT_DATA_LENGTH,
  parameter int WEIGHT_LENGTH = DEFAULT_WEIGHT_LENGTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_weight_we,
  input  logic [idx_width(NUM_INPUTS)-1:0] i_weight_addr,
  input  logic [WEIGHT_LENGTH-1:0]         i_weight_data,
  input  logic                             i_start,
  input  logic [NUM_INPUTS-1:0]            i_spikes,
  output logic                             o_busy,
  output logic                             o_valid,
  output logic [DATA_LENGTH-1:0]           o_current
);

  localparam int IDX_W = idx_width(NUM_INPUTS);
  // One bit wider than the larger operand so the raw sum never wraps
  // before it is compared against the saturation limit.
  localparam int SUM_W = ((DATA_LENGTH > WEIGHT_LENGTH) ? DATA_LENGTH : WEIGHT_LENGTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [SUM_W-1:0] SAT_MAX  = {{(SUM_W - DATA_LENGTH){1'b0}}, {DATA_LENGTH{1'b1}}};

  syn_state_t               state;
  syn_state_t               state_next;
  logic [IDX_W-1:0]         index;
  logic [NUM_INPUTS-1:0]    spikes_latched;
  logic [DATA_LENGTH-1:0]   acc;
  logic [DATA_LENGTH-1:0]   acc_sat;
  logic [WEIGHT_LENGTH-1:0] weight_rd;
  logic [SUM_W-1:0]         sum_wide;

  synapse_weight_regfile #(
    .NUM_ENTRIES (NUM_INPUTS),
    .WIDTH       (WEIGHT_LENGTH)
  ) u_weights (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (i_weight_we),
    .waddr (i_weight_addr),
    .wdata (i_weight_data),
    .raddr (index),
    .rdata (weight_rd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_ACCUM;
      ST_ACCUM: if (index == LAST_IDX) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Once the accumulator reaches the limit, adding a non-negative weight
  // keeps it there, which is what makes saturation sticky.
  always_comb begin
    sum_wide = {{(SUM_W - DATA_LENGTH){1'b0}}, acc}
             + {{(SUM_W - WEIGHT_LENGTH){1'b0}}, weight_rd};
    acc_sat  = (sum_wide > SAT_MAX) ? {DATA_LENGTH{1'b1}} : sum_wide[DATA_LENGTH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index          <= '0;
      acc            <= '0;
      spikes_latched <= '0;
      o_valid        <= 1'b0;
      o_current      <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            spikes_latched <= i_spikes;
            acc            <= '0;
            index          <= '0;
          end
        end
        ST_ACCUM: begin
          if (spikes_latched[index]) begin
            acc <= acc_sat;
          end
          index <= index + IDX_W'(1);
        end
        ST_DONE: begin
          o_current <= acc;
          o_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_synapse_accumulator.sv
// Self-checking bench for synapse_accumulator with default parameters.
// Expected sums come from a reference weight array: the sum of weights of
// active inputs, clipped at 255, with mid-sum writes only visible to inputs
// not yet read.
module tb_synapse_accumulator;

  localparam int N = 8;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_weight_we;
  logic [2:0] i_weight_addr;
  logic [7:0] i_weight_data;
  logic       i_start;
  logic [7:0] i_spikes;
  logic       o_busy;
  logic       o_valid;
  logic [7:0] o_current;

  int errorCount = 0;
  int checkCount = 0;
  int modelWeight [N];

  synapse_accumulator dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_weight_we   (i_weight_we),
    .i_weight_addr (i_weight_addr),
    .i_weight_data (i_weight_data),
    .i_start       (i_start),
    .i_spikes      (i_spikes),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .o_current     (o_current)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Write one weight while the accumulator is idle and mirror it in the model.
  task automatic writeWeight(input int addr, input int data);
    i_weight_we   = 1'b1;
    i_weight_addr = addr[2:0];
    i_weight_data = data[7:0];
    tick();
    i_weight_we = 1'b0;
    modelWeight[addr] = data;
  endtask

  // Runs one timestep. Optional disturbances: a second start strobe at
  // restartCycle, toggling spikes after the latch, and a weight write at
  // writeCycle. Cycle c is the cycle following the c-th edge after the
  // start edge; input c is read during cycle c.
  task automatic applyStimulus(input logic [7:0] spikes, input int restartCycle,
                               input bit toggleSpikes, input int writeCycle,
                               input int writeAddr, input int writeData, input string tag);
    int total;
    int w;
    int expected;
    int busyCycles;
    int validAt;
    int validPulses;
    int currentAtValid;
    total = 0;
    for (int i = 0; i < N; i++) begin
      if (spikes[i]) begin
        w = modelWeight[i];
        if (writeCycle >= 0 && i == writeAddr && i > writeCycle) w = writeData;
        total += w;
      end
    end
    expected = (total > 255) ? 255 : total;

    i_spikes = spikes;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    busyCycles     = 0;
    validAt        = -1;
    validPulses    = 0;
    currentAtValid = -1;
    for (int c = 0; c < 20; c++) begin
      if (o_busy) busyCycles++;
      if (o_valid) begin
        validPulses++;
        if (validAt < 0) begin
          validAt        = c;
          currentAtValid = int'(o_current);
        end
      end
      i_start     = (c == restartCycle);
      i_spikes    = (toggleSpikes && c >= 0 && c[0] == 1'b0) ? ~spikes : spikes;
      i_weight_we = (c == writeCycle);
      if (c == writeCycle) begin
        i_weight_addr = writeAddr[2:0];
        i_weight_data = writeData[7:0];
      end
      tick();
    end
    i_start     = 1'b0;
    i_weight_we = 1'b0;
    i_spikes    = spikes;
    if (writeCycle >= 0) modelWeight[writeAddr] = writeData;

    checkOutput({tag, " valid_latency"}, validAt, 9);
    checkOutput({tag, " valid_pulses"}, validPulses, 1);
    checkOutput({tag, " busy_cycles"}, busyCycles, N + 1);
    checkOutput({tag, " current_at_valid"}, currentAtValid, expected);
    checkOutput({tag, " current_held"}, o_current, expected);
  endtask

  // Main sequence: reset state, directed scenarios, randomized timesteps,
  // then an asynchronous reset in the middle of a sum.
  initial begin
    int validPulses;
    int busyCycles;
    i_rst_n       = 1'b0;
    i_weight_we   = 1'b0;
    i_weight_addr = '0;
    i_weight_data = '0;
    i_start       = 1'b0;
    i_spikes      = '0;
    for (int i = 0; i < N; i++) modelWeight[i] = 0;

    #12;
    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset valid", o_valid, 0);
    checkOutput("reset current", o_current, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    applyStimulus(8'hFF, -1, 1'b0, -1, 0, 0, "zero_weights");

    for (int i = 0; i < N; i++) writeWeight(i, i + 1);
    applyStimulus(8'b0000_0101, -1, 1'b0, -1, 0, 0, "sparse_sum");
    applyStimulus(8'b1001_0010, 3, 1'b1, -1, 0, 0, "restart_toggle");

    for (int i = 0; i < N; i++) writeWeight(i, 100);
    applyStimulus(8'h07, -1, 1'b0, -1, 0, 0, "saturate");
    applyStimulus(8'h01, -1, 1'b0, -1, 0, 0, "after_saturate");

    writeWeight(2, 10);
    applyStimulus(8'h04, -1, 1'b0, 2, 2, 50, "rbw_old");
    applyStimulus(8'h04, -1, 1'b0, -1, 0, 0, "rbw_new");

    for (int t = 0; t < 8; t++) begin
      int hi;
      int wc;
      hi = (t[0] == 1'b0) ? 60 : 255;
      for (int k = 0; k < 3; k++) writeWeight($urandom_range(0, N - 1), $urandom_range(0, hi));
      wc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
      applyStimulus(8'($urandom), (t == 5) ? 4 : -1, t[1], wc,
                    $urandom_range(0, N - 1), $urandom_range(0, hi), "random");
    end

    writeWeight(0, 9);
    applyStimulus(8'h01, -1, 1'b0, -1, 0, 0, "pre_reset");

    i_spikes = 8'hFF;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", o_busy, 0);
    checkOutput("midreset valid", o_valid, 0);
    checkOutput("midreset current", o_current, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < N; i++) modelWeight[i] = 0;
    validPulses = 0;
    busyCycles  = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid) validPulses++;
      if (o_busy) busyCycles++;
      tick();
    end
    checkOutput("postreset no_valid", validPulses, 0);
    checkOutput("postreset no_busy", busyCycles, 0);
    applyStimulus(8'hFF, -1, 1'b0, -1, 0, 0, "weights_cleared");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/synapse_accumulator.md
SYNAPSE_ACCUMULATOR -- requirements
Module: synapse_accumulator

Interface
REQ-001 Parameter NUM_INPUTS, default 8: number of presynaptic spike lines and weights.
REQ-002 Parameter DATA_LENGTH, default 8: width of the output current and of the downstream neuron's i_spike input.
REQ-003 Parameter WEIGHT_LENGTH, default 8: width of each unsigned synaptic weight.
REQ-004 i_clk  input  1  single clock, all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_weight_we  input  1  weight write enable.
REQ-007 i_weight_addr  input  clog2(NUM_INPUTS)  weight write index.
REQ-008 i_weight_data  input  WEIGHT_LENGTH  weight write value.
REQ-009 i_start  input  1  timestep strobe; requests one weighted sum of i_spikes.
REQ-010 i_spikes  input  NUM_INPUTS  presynaptic spike vector, one bit per input.
REQ-011 o_busy  output  1  high while a sum is in progress.
REQ-012 o_valid  output  1  one-cycle pulse when o_current is updated.
REQ-013 o_current  output  DATA_LENGTH  saturated weighted sum; feeds the neuron's i_spike input.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE with i_start=1: latch i_spikes, clear accumulator, clear index to 0, go to ACCUM, assert o_busy.
REQ-016 ACCUM, each cycle: if latched spike[index]=1, add weight[index] to accumulator; otherwise hold the accumulator.
REQ-017 ACCUM: index increments each cycle; after processing index NUM_INPUTS-1, go to DONE.
REQ-018 DONE: load o_current from accumulator, pulse o_valid for exactly one cycle, deassert o_busy, return to IDLE.
REQ-019 Latency: if i_start is sampled at edge k, o_valid is high during the cycle after edge k+NUM_INPUTS+1.
REQ-020 Throughput: i_start is accepted again in the IDLE cycle following DONE, giving one sum per NUM_INPUTS+2 cycles.
REQ-021 Arithmetic: the accumulator saturates at 2^DATA_LENGTH-1.
REQ-022 Saturation is sticky within a timestep, so no wrap-around is possible.
REQ-023 Weights wider than DATA_LENGTH are added at full width before the saturation compare.
REQ-024 i_start while o_busy=1 is ignored, with no queueing.
REQ-025 Changes on i_spikes after the latch edge do not affect the current sum.
REQ-026 Weight writes are accepted in every state.
REQ-027 A write to the index being read in the same cycle uses the old weight (read-before-write); the new value applies from the next read.
REQ-028 o_current holds its value between o_valid pulses.
REQ-029 o_valid=1 and o_busy=0 never occur in the same cycle as o_busy=1 from a new start; a start can first be sampled in the cycle after DONE.

Reset
REQ-030 i_rst_n=0 asynchronously forces: state IDLE, index 0, accumulator 0, latched spikes 0, all weights 0, o_busy 0, o_valid 0, o_current 0.
REQ-031 Reset asserted mid-ACCUM aborts the sum, produces no o_valid pulse, and discards the partial sum.
REQ-032 After reset deasserts, the first rising edge with i_start=1 starts a new sum normally.

Structure
REQ-033 The FSM state encodings and the parameter defaults live in the shared include file used by the neuron blocks.
REQ-034 The weight storage is one sub-module, synapse_weight_regfile, with one write port and one combinational read port indexed by the FSM.
REQ-035 synapse_weight_regfile has asynchronous active-low reset to 0.
REQ-036 The FSM, index counter, accumulator and saturation logic stay in synapse_accumulator.

Verification
REQ-037 Reset, then weights untouched, i_spikes=8'hFF, i_start -> o_valid at cycle 9 after start, o_current=0.
REQ-038 Weights w[i]=i+1, i_spikes=8'b0000_0101 -> o_current=4 (1+3), o_busy high for exactly 9 cycles.
REQ-039 All weights=100, i_spikes=8'h07 -> o_current=255 (saturated, not 44); next timestep with i_spikes=8'h01 -> o_current=100.
REQ-040 i_start re-pulsed mid-ACCUM, and i_spikes toggled after latch -> single o_valid, sum from the original latched vector only.
REQ-041 i_rst_n pulsed low during ACCUM index 3 -> o_busy, o_valid, o_current immediately 0; no o_valid pulse; all weights read back 0.
REQ-042 w[2]=10, write w[2]=50 in the cycle index=2 is read, i_spikes=8'h04 -> o_current=10; next timestep -> o_current=50.
